icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
Read-only, direct-mapped instruction cache between the pipelined RV32IC core's ICACHE_* port and the 128-bit instruction memory. It serves 32-bit word fetches on hit with zero added latency. On a miss it stalls the core, refills one 4-word line from memory, and then resumes. The core never writes instructions, so writes are ignored.

Parameters:
NUM_LINES, 8, number of cache lines; power of two, at least 2; IDX_W = log2(NUM_LINES)
TAG_W, 28 - IDX_W (25 by default), derived localparam; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
proc_read  in  1  fetch request (core ICACHE_ren)
proc_write  in  1  write request; always 0 from the core and ignored
proc_addr  in  30  word address: [1:0] word-in-line, [IDX_W+1:2] index, [29:IDX_W+2] tag
proc_wdata  in  32  ignored
proc_stall  out  1  core must hold its request and pipeline
proc_rdata  out  32  selected instruction word, byte order passed through unmodified
mem_read  out  1  line read request to memory
mem_write  out  1  tied 0
mem_addr  out  28  line address = proc_addr[29:2] of the missing fetch
mem_wdata  out  128  tied 0
mem_rdata  in  128  line data; word k at bits [32k+31:32k]
mem_ready  in  1  one-cycle pulse; mem_rdata is valid in the same cycle

Behaviour:
- Storage: per line, one valid bit, a TAG_W tag and 128 data bits. Data and tag arrays need no reset.
- hit = valid[idx] & (tag[idx] == proc_addr tag field).
- proc_rdata = data[idx] word selected by proc_addr[1:0]. It is combinational and is don't-care when not a hit.
- FSM states: IDLE, ALLOCATE.
- IDLE:
  - proc_read & hit -> proc_stall=0; stay in IDLE.
  - proc_read & !hit -> proc_stall=1 combinationally; latch {tag,idx} into miss_addr_r; next state ALLOCATE.
  - !proc_read -> proc_stall=0; no state change.
- ALLOCATE:
  - mem_read=1, mem_addr=miss_addr_r, proc_stall=1.
  - On mem_ready: write mem_rdata into line miss_addr_r[IDX_W-1:0], set its tag and valid bit, go to IDLE.
  - The next IDLE cycle re-evaluates the hit with the core's held address.
- Miss penalty: 1 cycle in IDLE + N cycles in ALLOCATE until mem_ready + 0, i.e. the fetch completes in the IDLE cycle after the refill.
- mem_read is 0 in IDLE. mem_addr holds miss_addr_r at all times.
- A memory request, once issued, is never aborted. If proc_read drops or proc_addr changes during ALLOCATE (core branch redirect), the refill still completes into the latched line. The new address is then looked up in IDLE.
- The refill overwrites the indexed line unconditionally (conflict eviction); there is no replacement choice.
- proc_write=1 is ignored: no stall, no state change. When proc_read is also 1, it is treated as a read.
- Reset (including during ALLOCATE):
  - state -> IDLE; all valid bits cleared; miss_addr_r -> 0.
  - mem_read=0 and proc_stall=0 from the first cycle after reset.
  - Any mem_ready arriving after reset is ignored.
- mem_ready while in IDLE is ignored.

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - hit_cnt increments in each IDLE cycle with proc_read & hit.
  - miss_cnt increments on each IDLE -> ALLOCATE transition.
  - Both wrap at 2^32 - 1 -> 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Cold miss. After reset, read proc_addr=0x0000_0001. Required: proc_stall=1 and mem_read=1 with mem_addr=0. Apply mem_ready after 3 cycles with mem_rdata={W3,W2,W1,W0}. The next cycle gives proc_stall=0 and proc_rdata=W1.
2. Hit sweep. After test 1, read addresses 0,1,2,3 back-to-back. Required: proc_stall=0 every cycle; proc_rdata = W0, W1, W2, W3; mem_read stays 0.
3. Conflict eviction with NUM_LINES=8. Read 0x00 (line 0 filled), then 0x20 (same index, different tag). Required: miss with mem_addr=0x08; after refill, reading 0x00 misses again with mem_addr=0x00.
4. Redirect during refill. Miss on 0x10, then during ALLOCATE change proc_addr to 0x40 and drop proc_read for one cycle. Required: mem_addr stays 0x04 until mem_ready and line 4 is filled. Then 0x40 misses with mem_addr=0x10.
5. Reset mid-refill. Assert rst_n=0 during ALLOCATE for 1 cycle. Required: mem_read=0 the next cycle. A later read of the previously valid 0x01 misses, because valid bits were cleared.
6. Write ignored (and counters with ICACHE_PERF_CNT_EN). Assert proc_write=1, proc_read=0. Required: proc_stall=0 and no memory request. After tests 1 and 2: hit_cnt=5 (test 1's completion cycle plus test 2's 4 hits), miss_cnt=1.

Source files
------------

// File: rtl/icache_direct_mapped_if.sv
// icache_direct_mapped_if: fetch-side and memory-side bus of the instruction cache.
//   slave  modport: the cache (takes fetches and memory replies, drives stall/data and line requests)
//   master modport: the environment (core fetch port plus 128-bit instruction memory)
//   proc_read/proc_write/proc_addr[29:0]/proc_wdata[31:0] -> cache; proc_stall/proc_rdata[31:0] <- cache
//   mem_read/mem_write/mem_addr[27:0]/mem_wdata[127:0] <- cache; mem_rdata[127:0]/mem_ready -> cache
interface icache_direct_mapped_if;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: read-only direct-mapped instruction cache, 4-word lines, zero-latency hits.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : core fetch port (proc_*) and 128-bit line refill port (mem_*)
//   hit_cnt_o/miss_cnt_o : hit and miss counters, present only when ICACHE_PERF_CNT_EN is defined
// Misses stall the core, refill one line, and the held fetch is re-looked-up the cycle after.
module icache_direct_mapped #(
   parameter int NUM_LINES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   icache_direct_mapped_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`endif
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 28 - IDX_W;
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] ALLOCATE = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [27:0]          miss_addr_q, miss_addr_d;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];
   logic [127:0]         data_q [NUM_LINES];
   logic [IDX_W-1:0]     idx, fill_idx;
   logic [TAG_W-1:0]     tag;
   logic [1:0]           word;
   logic                 hit, miss, refill;
   logic                 unused_bus;

   assign idx      = bus.proc_addr[IDX_W+1:2];
   assign tag      = bus.proc_addr[29:IDX_W+2];
   assign word     = bus.proc_addr[1:0];
   assign fill_idx = miss_addr_q[IDX_W-1:0];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   assign miss     = (state_q == IDLE) && bus.proc_read && !hit;
   // A launched refill always completes, whatever the core does to proc_read/proc_addr meanwhile.
   assign refill   = (state_q == ALLOCATE) && bus.mem_ready;

   always_comb begin
      state_d     = miss ? ALLOCATE : refill ? IDLE : state_q;
      miss_addr_d = miss ? bus.proc_addr[29:2] : miss_addr_q;
      valid_d     = valid_q;
      if (refill) valid_d[fill_idx] = 1'b1;
   end

   assign bus.proc_stall = (state_q == ALLOCATE) || miss;
   assign bus.proc_rdata = data_q[idx][{word, 5'b0} +: 32];
   assign bus.mem_read   = (state_q == ALLOCATE);
   assign bus.mem_addr   = miss_addr_q;
   assign bus.mem_write  = 1'b0;
   assign bus.mem_wdata  = '0;
   // Writes never come from the core; these inputs are intentionally dropped.
   assign unused_bus     = ^{bus.proc_write, bus.proc_wdata};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         miss_addr_q <= miss_addr_d;
      end
   end

   // Tag and data arrays carry no reset; validity alone governs hits.
   always_ff @(posedge clk) begin
      if (rst_n && refill) begin
         data_q[fill_idx] <= bus.mem_rdata;
         tag_q[fill_idx]  <= miss_addr_q[27:IDX_W];
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_q + 32'((state_q == IDLE) && bus.proc_read && hit);
         miss_cnt_q <= miss_cnt_q + 32'(miss);
      end
   end
   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed self-checking bench for icache_direct_mapped (NUM_LINES=8).
module tb_icache_direct_mapped;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   icache_direct_mapped_if bus();

   icache_direct_mapped #(.NUM_LINES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [127:0] L1 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
   localparam logic [127:0] L2 = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
   localparam logic [127:0] L4 = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
   localparam logic [127:0] L5 = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs changed afterwards settle before the #1 probe in each check site.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold ALLOCATE for `waits` cycles checking the request, then return the line with a mem_ready pulse.
   task automatic refill(input string tag, input logic [127:0] line, input int waits, input logic [27:0] exp_addr);
      for (int i = 0; i < waits; i++) begin
         #1;
         check({tag, "_mem_read"}, bus.mem_read, 1'b1);
         check({tag, "_mem_addr"}, bus.mem_addr, exp_addr);
         check({tag, "_stall"}, bus.proc_stall, 1'b1);
         step();
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line;
      #1;
      check({tag, "_mem_addr_rdy"}, bus.mem_addr, exp_addr);
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = '0;
      bus.proc_wdata = '0;
      bus.mem_rdata  = '0;
      bus.mem_ready  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("rst_stall", bus.proc_stall, 1'b0);
      check("rst_mem_read", bus.mem_read, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 28'h0);
      check("rst_mem_write", bus.mem_write, 1'b0);
      check("rst_mem_wdata", bus.mem_wdata, 128'h0);
`ifdef ICACHE_PERF_CNT_EN
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
      // 1: cold miss on word 1 of line 0
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h1;
      #1;
      check("t1_stall_comb", bus.proc_stall, 1'b1);
      check("t1_idle_mem_read", bus.mem_read, 1'b0);
      step();
      refill("t1", L1, 3, 28'h0);
      #1;
      check("t1_done_stall", bus.proc_stall, 1'b0);
      check("t1_done_rdata", bus.proc_rdata, 32'h1111_1111);
      check("t1_done_mem_read", bus.mem_read, 1'b0);
      step();
      // 2: hit sweep over line 0
      for (int i = 0; i < 4; i++) begin
         bus.proc_addr = 30'(i);
         #1;
         check($sformatf("t2_stall%0d", i), bus.proc_stall, 1'b0);
         check($sformatf("t2_rdata%0d", i), bus.proc_rdata, {4{8'(i * 8'h11)}});
         check($sformatf("t2_mem_read%0d", i), bus.mem_read, 1'b0);
         step();
      end
      // 6: write-only request is ignored
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b1;
      bus.proc_wdata = 32'hDEAD_BEEF;
      #1;
      check("t6_stall", bus.proc_stall, 1'b0);
      check("t6_mem_read", bus.mem_read, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
      check("t6_hit_cnt", hit_cnt, 32'd5);
      check("t6_miss_cnt", miss_cnt, 32'd1);
`endif
      step();
      check("t6_mem_read_after", bus.mem_read, 1'b0);
      check("t6_stall_after", bus.proc_stall, 1'b0);
      // a stray mem_ready in IDLE must change nothing
      bus.proc_write = 1'b0;
      bus.mem_ready  = 1'b1;
      bus.mem_rdata  = L5;
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      #1;
      check("idle_rdy_mem_read", bus.mem_read, 1'b0);
      // 3: conflict eviction on index 0
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h00;
      #1;
      check("t3_hit0_stall", bus.proc_stall, 1'b0);
      check("t3_hit0_rdata", bus.proc_rdata, 32'h0000_0000);
      step();
      bus.proc_addr = 30'h20;
      #1;
      check("t3_miss20_stall", bus.proc_stall, 1'b1);
      step();
      refill("t3a", L2, 1, 28'h08);
      #1;
      check("t3_hit20_stall", bus.proc_stall, 1'b0);
      check("t3_hit20_rdata", bus.proc_rdata, 32'hA0A0_A0A0);
      step();
      bus.proc_addr = 30'h00;
      #1;
      check("t3_remiss0_stall", bus.proc_stall, 1'b1);
      step();
      refill("t3b", L1, 2, 28'h00);
      // 4: redirect while refilling line 4
      bus.proc_addr = 30'h10;
      #1;
      check("t4_miss10_stall", bus.proc_stall, 1'b1);
      step();
      bus.proc_addr = 30'h40;
      bus.proc_read = 1'b0;
      #1;
      check("t4_redir_mem_addr", bus.mem_addr, 28'h04);
      check("t4_redir_stall", bus.proc_stall, 1'b1);
      step();
      bus.proc_read = 1'b1;
      refill("t4a", L4, 1, 28'h04);
      #1;
      check("t4_miss40_stall", bus.proc_stall, 1'b1);
      step();
      refill("t4b", L5, 1, 28'h10);
      #1;
      check("t4_hit40_rdata", bus.proc_rdata, 32'hD0D0_D0D0);
      step();
      bus.proc_addr = 30'h12;
      #1;
      check("t4_hit12_stall", bus.proc_stall, 1'b0);
      check("t4_hit12_rdata", bus.proc_rdata, 32'hC2C2_C2C2);
      step();
      // 5: reset in the middle of a refill of line 2
      bus.proc_addr = 30'h08;
      step();
      #1;
      check("t5_alloc_mem_read", bus.mem_read, 1'b1);
      check("t5_alloc_mem_addr", bus.mem_addr, 28'h02);
      rst_n         = 1'b0;
      bus.proc_read = 1'b0;
      step();
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = L2;
      #1;
      check("t5_mem_read", bus.mem_read, 1'b0);
      check("t5_stall", bus.proc_stall, 1'b0);
      check("t5_mem_addr", bus.mem_addr, 28'h0);
      step();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      #1;
      check("t5_late_rdy_mem_read", bus.mem_read, 1'b0);
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h01;
      #1;
      check("t5_remiss01_stall", bus.proc_stall, 1'b1);
      step();
      refill("t5a", L1, 1, 28'h00);
      bus.proc_addr = 30'h12;
      #1;
      check("t5_remiss12_stall", bus.proc_stall, 1'b1);
      step();
      refill("t5b", L4, 0, 28'h04);
      #1;
      check("t5_hit12_rdata", bus.proc_rdata, 32'hC2C2_C2C2);
`ifdef ICACHE_PERF_CNT_EN
      check("t5_miss_cnt", miss_cnt, 32'd2);
`endif
      bus.proc_read = 1'b0;
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
